// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester (icache / dcache) arbiter for one shared memory
//            port. Each transaction is atomic, and every transaction is
//            re-arbitrated through IDLE.
// Options  : MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
//            When it is undefined, the dcache wins every tie.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
) (
   input  logic              clk_i,
   input  logic              rst_ni,

   input  logic              ic_valid_i,
   input  logic              ic_rw_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   input  logic [LINE_W-1:0] ic_wdata_i,
   output logic              ic_ready_o,
   output logic [LINE_W-1:0] ic_rdata_o,

   input  logic              dc_valid_i,
   input  logic              dc_rw_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic [LINE_W-1:0] dc_wdata_i,
   output logic              dc_ready_o,
   output logic [LINE_W-1:0] dc_rdata_o,

   output logic              mem_valid_o,
   output logic              mem_rw_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic [LINE_W-1:0] mem_rdata_i,

   output logic [31:0]       ic_grant_cnt_o,
   output logic [31:0]       dc_grant_cnt_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT_IC = 2'd1,
      GRANT_DC = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        ic_done;
   logic        dc_done;
   logic        dc_wins_tie;
   logic [31:0] ic_cnt;
   logic [31:0] dc_cnt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // last_dc = 1 means the dcache completed most recently; reset = icache last
   logic last_dc;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_dc <= 1'b0;
      end else if (dc_done) begin
         last_dc <= 1'b1;
      end else if (ic_done) begin
         last_dc <= 1'b0;
      end
   end

   assign dc_wins_tie = ~last_dc;
`else
   assign dc_wins_tie = 1'b1;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A completion needs the granted requester to still be asking
   assign ic_done = (state == GRANT_IC) && ic_valid_i && mem_ready_i;
   assign dc_done = (state == GRANT_DC) && dc_valid_i && mem_ready_i;

   always_comb begin
      state_nxt   = state;
      mem_valid_o = 1'b0;
      mem_rw_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      ic_ready_o  = 1'b0;
      ic_rdata_o  = '0;
      dc_ready_o  = 1'b0;
      dc_rdata_o  = '0;

      case (state)
         IDLE: begin
            if (ic_valid_i && dc_valid_i) begin
               state_nxt = dc_wins_tie ? GRANT_DC : GRANT_IC;
            end else if (dc_valid_i) begin
               state_nxt = GRANT_DC;
            end else if (ic_valid_i) begin
               state_nxt = GRANT_IC;
            end
         end

         GRANT_IC: begin
            mem_valid_o = ic_valid_i;
            mem_rw_o    = ic_rw_i;
            mem_addr_o  = ic_addr_i;
            mem_wdata_o = ic_wdata_i;
            if (ic_done) begin
               ic_ready_o = 1'b1;
               ic_rdata_o = mem_rdata_i;
            end
            if (!ic_valid_i || mem_ready_i) begin
               state_nxt = IDLE;
            end
         end

         GRANT_DC: begin
            mem_valid_o = dc_valid_i;
            mem_rw_o    = dc_rw_i;
            mem_addr_o  = dc_addr_i;
            mem_wdata_o = dc_wdata_i;
            if (dc_done) begin
               dc_ready_o = 1'b1;
               dc_rdata_o = mem_rdata_i;
            end
            if (!dc_valid_i || mem_ready_i) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ic_cnt <= 32'd0;
         dc_cnt <= 32'd0;
      end else begin
         if (ic_done) begin
            ic_cnt <= ic_cnt + 32'd1;
         end
         if (dc_done) begin
            dc_cnt <= dc_cnt + 32'd1;
         end
      end
   end

   assign ic_grant_cnt_o = ic_cnt;
   assign dc_grant_cnt_o = dc_cnt;

endmodule
`default_nettype wire
